// File: rtl/date_counter.sv
// Calendar date register: advances day/month/year on day ticks, supports per-field
// user adjustment, and clamps the day after a month/year change once leap_year settles.
module date_counter #(
   parameter int YEAR_RESET = 2000,
   parameter int YEAR_MAX   = 4095
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        day_tick,
   input  logic        leap_year,
   input  logic [1:0]  adj_sel,
   input  logic        adj_inc,
   input  logic        adj_dec,
   output logic [4:0]  day,
   output logic [3:0]  month,
   output logic [11:0] year_bin,
   output logic        year_wrap,
   output logic        tick_lost
);

   typedef enum logic [1:0] {
      ADJ_DAY   = 2'd0,
      ADJ_MONTH = 2'd1,
      ADJ_YEAR  = 2'd2,
      ADJ_NONE  = 2'd3
   } adj_sel_e;

   localparam logic [11:0] YMAX   = 12'(YEAR_MAX);
   localparam logic [11:0] YRESET = 12'(YEAR_RESET);

   logic [4:0]  day_q, day_d;
   logic [3:0]  month_q, month_d;
   logic [11:0] year_q, year_d;
   logic        year_wrap_q, year_wrap_d;
   logic        tick_lost_q, tick_lost_d;
   logic        fix_pending_q, fix_pending_d;
   logic        tick_pending_q, tick_pending_d;

   logic [4:0]  max_day;
   adj_sel_e    sel;
   logic        adjust;
   logic        blocked;

   assign sel     = adj_sel_e'(adj_sel);
   assign adjust  = (adj_inc ^ adj_dec) && (sel != ADJ_NONE);
   assign blocked = adjust || fix_pending_q;

   // February length depends on the leap stage, which sees our registered year.
   always_comb begin
      max_day = 5'd31;
      unique case (month_q)
         4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
         4'd2:                    max_day = leap_year ? 5'd29 : 5'd28;
         default:                 max_day = 5'd31;
      endcase
   end

   always_comb begin
      day_d          = day_q;
      month_d        = month_q;
      year_d         = year_q;
      year_wrap_d    = 1'b0;
      tick_lost_d    = tick_lost_q;
      fix_pending_d  = fix_pending_q;
      tick_pending_d = tick_pending_q;

      if (adjust) begin
         unique case (sel)
            ADJ_DAY: begin
               if (adj_inc) day_d = (day_q >= max_day) ? 5'd1 : day_q + 5'd1;
               else         day_d = (day_q <= 5'd1) ? max_day : day_q - 5'd1;
            end
            ADJ_MONTH: begin
               if (adj_inc) month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
               else         month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
               fix_pending_d = 1'b1;
            end
            ADJ_YEAR: begin
               if (adj_inc) year_d = (year_q >= YMAX) ? 12'd0 : year_q + 12'd1;
               else         year_d = (year_q == 12'd0) ? YMAX : year_q - 12'd1;
               fix_pending_d = 1'b1;
            end
            default: ;
         endcase
      end else if (fix_pending_q) begin
         if (day_q > max_day) day_d = max_day;
         fix_pending_d = 1'b0;
      end else if (day_tick || tick_pending_q) begin
         tick_pending_d = 1'b0;
         if (day_tick && tick_pending_q) tick_lost_d = 1'b1;
         if (day_q < max_day) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (month_q >= 4'd12) begin
               month_d = 4'd1;
               if (year_q >= YMAX) begin
                  year_d      = 12'd0;
                  year_wrap_d = 1'b1;
               end else begin
                  year_d = year_q + 12'd1;
               end
            end else begin
               month_d = month_q + 4'd1;
            end
         end
      end

      // Only one tick can wait behind an adjust/fix; a second one is lost.
      if (blocked && day_tick) begin
         if (tick_pending_q) tick_lost_d = 1'b1;
         tick_pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         day_q          <= 5'd1;
         month_q        <= 4'd1;
         year_q         <= YRESET;
         year_wrap_q    <= 1'b0;
         tick_lost_q    <= 1'b0;
         fix_pending_q  <= 1'b0;
         tick_pending_q <= 1'b0;
      end else begin
         day_q          <= day_d;
         month_q        <= month_d;
         year_q         <= year_d;
         year_wrap_q    <= year_wrap_d;
         tick_lost_q    <= tick_lost_d;
         fix_pending_q  <= fix_pending_d;
         tick_pending_q <= tick_pending_d;
      end
   end

   assign day       = day_q;
   assign month     = month_q;
   assign year_bin  = year_q;
   assign year_wrap = year_wrap_q;
   assign tick_lost = tick_lost_q;

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: leap-year stage in the feedback loop, a calendar-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_date_counter;

   logic        clk;
   logic        rst;
   logic        day_tick;
   logic        leap_year;
   logic [1:0]  adj_sel;
   logic        adj_inc;
   logic        adj_dec;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [11:0] year_bin;
   logic        year_wrap;
   logic        tick_lost;

   int checks = 0;
   int errors = 0;

   int  m_day, m_month, m_year;
   bit  m_wrap, m_lost, m_fix, m_pend;
   bit  model_valid = 0;
   int  yr;

   date_counter #(.YEAR_RESET(2000), .YEAR_MAX(4095)) dut (
      .clk       (clk),
      .rst       (rst),
      .day_tick  (day_tick),
      .leap_year (leap_year),
      .adj_sel   (adj_sel),
      .adj_inc   (adj_inc),
      .adj_dec   (adj_dec),
      .day       (day),
      .month     (month),
      .year_bin  (year_bin),
      .year_wrap (year_wrap),
      .tick_lost (tick_lost)
   );

   // Downstream leap-year stage, combinational on the DUT's year.
   always_comb begin
      yr = int'(year_bin);
      leap_year = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit isLeap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int daysIn(input int m, input int y);
      case (m)
         4, 6, 9, 11: return 30;
         2:           return isLeap(y) ? 29 : 28;
         default:     return 31;
      endcase
   endfunction

   // Reference calendar: one step per clock, from the date rules in plain arithmetic.
   always @(posedge clk) begin
      int  mx;
      bit  is_adj, busy;
      if (rst) begin
         m_day = 1; m_month = 1; m_year = 2000;
         m_wrap = 0; m_lost = 0; m_fix = 0; m_pend = 0;
         model_valid = 1;
      end else if (model_valid) begin
         mx     = daysIn(m_month, m_year);
         is_adj = (adj_inc != adj_dec) && (adj_sel != 2'd3);
         busy   = is_adj || m_fix;
         m_wrap = 0;
         if (is_adj) begin
            if (adj_sel == 2'd0) begin
               if (adj_inc) m_day = (m_day >= mx) ? 1 : m_day + 1;
               else         m_day = (m_day <= 1) ? mx : m_day - 1;
            end else if (adj_sel == 2'd1) begin
               m_month = adj_inc ? (m_month % 12) + 1 : ((m_month + 10) % 12) + 1;
               m_fix = 1;
            end else begin
               m_year = adj_inc ? (m_year + 1) % 4096 : (m_year + 4095) % 4096;
               m_fix = 1;
            end
         end else if (m_fix) begin
            if (m_day > mx) m_day = mx;
            m_fix = 0;
         end else if (day_tick || m_pend) begin
            if (day_tick && m_pend) m_lost = 1;
            m_pend = 0;
            if (m_day < mx) m_day = m_day + 1;
            else begin
               m_day = 1;
               if (m_month == 12) begin
                  m_month = 1;
                  if (m_year == 4095) begin m_year = 0; m_wrap = 1; end
                  else m_year = m_year + 1;
               end else m_month = m_month + 1;
            end
         end
         if (busy && day_tick) begin
            if (m_pend) m_lost = 1;
            m_pend = 1;
         end
      end
   end

   task automatic checkVal(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         checkVal("cyc_day",   32'(day),       m_day);
         checkVal("cyc_month", 32'(month),     m_month);
         checkVal("cyc_year",  32'(year_bin),  m_year);
         checkVal("cyc_wrap",  32'(year_wrap), int'(m_wrap));
         checkVal("cyc_lost",  32'(tick_lost), int'(m_lost));
      end
   end

   task automatic applyStimulus(input logic [1:0] sel, input logic inc, input logic dec,
                                input logic tick, input logic rstv);
      adj_sel = sel; adj_inc = inc; adj_dec = dec; day_tick = tick; rst = rstv;
      @(negedge clk);
      adj_sel = 2'd3; adj_inc = 1'b0; adj_dec = 1'b0; day_tick = 1'b0; rst = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      applyStimulus(2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Literal expectations checked against both the DUT and the model.
   task automatic checkOutput(input string name, input int d, input int m, input int y,
                              input int w, input int l);
      checkVal({name, "_day"},   32'(day),       d);
      checkVal({name, "_month"}, 32'(month),     m);
      checkVal({name, "_year"},  32'(year_bin),  y);
      checkVal({name, "_wrap"},  32'(year_wrap), w);
      checkVal({name, "_lost"},  32'(tick_lost), l);
      checkVal({name, "_model_day"},   32'(m_day),   d);
      checkVal({name, "_model_month"}, 32'(m_month), m);
      checkVal({name, "_model_year"},  32'(m_year),  y);
   endtask

   // Walk the fields to a target date using adjust pulses, then let the fix run.
   task automatic setDate(input int d, input int m, input int y);
      int up;
      for (int i = 0; i < 4096 && m_year != y; i++) begin
         up = (y - m_year + 4096) % 4096;
         if (up <= 2048) applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
         else            applyStimulus(2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 12 && m_month != m; i++)
         applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle();
      for (int i = 0; i < 40 && m_day != d; i++) begin
         if (d < m_day) applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         else           applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL timeout: got no finish, expected finish within budget");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      adj_sel = 2'd3; adj_inc = 1'b0; adj_dec = 1'b0; day_tick = 1'b0; rst = 1'b0;
      @(negedge clk);

      $display("[TB] reset with coincident day_tick");
      applyStimulus(2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("reset", 1, 1, 2000, 0, 0);

      $display("[TB] February lengths");
      setDate(28, 2, 2000);
      tick(); checkOutput("feb2000_a", 29, 2, 2000, 0, 0);
      tick(); checkOutput("feb2000_b", 1, 3, 2000, 0, 0);
      setDate(28, 2, 1900);
      tick(); checkOutput("feb1900", 1, 3, 1900, 0, 0);
      setDate(28, 2, 2024);
      tick(); checkOutput("feb2024", 29, 2, 2024, 0, 0);

      $display("[TB] year rollover");
      setDate(31, 12, 4095);
      tick(); checkOutput("wrap_hi", 1, 1, 0, 1, 0);
      idle(); checkOutput("wrap_lo", 1, 1, 0, 0, 0);
      setDate(31, 12, 1999);
      tick(); checkOutput("y2k", 1, 1, 2000, 0, 0);

      $display("[TB] clamp after month/year adjust");
      setDate(31, 3, 2001);
      applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("clamp_m_pre", 31, 2, 2001, 0, 0);
      idle(); checkOutput("clamp_m_post", 28, 2, 2001, 0, 0);
      setDate(29, 2, 2000);
      applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("clamp_y_pre", 29, 2, 2001, 0, 0);
      idle(); checkOutput("clamp_y_post", 28, 2, 2001, 0, 0);

      $display("[TB] deferred and lost ticks");
      setDate(10, 1, 2000);
      applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("defer_adj", 11, 1, 2000, 0, 0);
      idle(); checkOutput("defer_tick", 12, 1, 2000, 0, 0);
      applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lost_a", 13, 1, 2000, 0, 0);
      applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("lost_b", 14, 1, 2000, 0, 1);
      idle(); checkOutput("lost_c", 15, 1, 2000, 0, 1);

      $display("[TB] reset discards pending work");
      applyStimulus(2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("pre_rst", 15, 2, 2000, 0, 1);
      applyStimulus(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("mid_rst", 1, 1, 2000, 0, 0);
      idle(); checkOutput("post_rst", 1, 1, 2000, 0, 0);

      $display("[TB] tick dropped while pending tick applies");
      applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("drop_a", 2, 1, 2000, 0, 0);
      tick(); checkOutput("drop_b", 3, 1, 2000, 0, 1);

      $display("[TB] null adjusts and day wrap");
      applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("both_day", 3, 1, 2000, 0, 1);
      applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("both_year", 3, 1, 2000, 0, 1);
      applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("sel_none", 3, 1, 2000, 0, 1);
      setDate(1, 4, 2000);
      applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("dec_wrap", 30, 4, 2000, 0, 1);
      applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_wrap", 1, 4, 2000, 0, 1);
      applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); checkOutput("apr_end", 1, 5, 2000, 0, 1);

      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
Calendar date register for the millennium clock. It advances day/month/year on each day-rollover tick from the time-of-day counter. It also supports user adjustment of each field.
- Drives `year_bin` to the downstream leap-year stage and consumes that stage's combinational `leap_year` result to size February.
- Outputs feed the display/BCD conversion path.

Parameters:
- YEAR_RESET, 2000, year loaded on reset (0..YEAR_MAX).
- YEAR_MAX, 4095, highest year; must be ≤ 4095 (12-bit `year_bin`).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- day_tick  in  1  one-cycle pulse, one per elapsed day
- leap_year  in  1  from leap-year stage; combinational function of this block's `year_bin` output
- adj_sel  in  2  field to adjust: 0 = day, 1 = month, 2 = year, 3 = none
- adj_inc  in  1  one-cycle pulse, increment the selected field
- adj_dec  in  1  one-cycle pulse, decrement the selected field
- day  out  5  day of month, 1..31
- month  out  4  month, 1..12
- year_bin  out  12  binary year, 0..YEAR_MAX
- year_wrap  out  1  one-cycle pulse when the year wraps from YEAR_MAX to 0 via day_tick
- tick_lost  out  1  sticky: a day_tick was dropped

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- **Reset values:** day = 1, month = 1, year_bin = YEAR_RESET, year_wrap = 0, tick_lost = 0, fix_pending = 0, tick_pending = 0.
- **Reset mid-operation:** any pending fix or tick is discarded.
- **max_day:**
  - months 4, 6, 9, 11 → 30
  - month 2 → 29 if leap_year = 1, else 28
  - all other months → 31
  - Always computed from the registered month and the current leap_year input.
- **Per-cycle priority:** rst > adjust > fix > tick.
- **Adjust cycle:** an adjust occurs when exactly one of adj_inc/adj_dec is high and adj_sel ≠ 3.
  - Both inc and dec high, or adj_sel = 3 → no change; the cycle does not count as an adjust.
  - Day: inc wraps max_day → 1; dec wraps 1 → max_day. Month and year unchanged.
  - Month: inc wraps 12 → 1; dec wraps 1 → 12. Sets fix_pending.
  - Year: inc wraps YEAR_MAX → 0; dec wraps 0 → YEAR_MAX. Sets fix_pending. year_wrap is not pulsed.
- **Fix cycle:** occurs in the cycle after a month/year adjust (fix_pending = 1, no new adjust that cycle).
  - The leap stage now sees the new year.
  - If day > max_day, day ← max_day; otherwise day is unchanged.
  - fix_pending clears.
  - If a new adjust arrives instead, it executes; fix_pending stays/sets and the fix runs on the next non-adjust cycle.
- **Tick:** applies when day_tick or tick_pending is set in a cycle with no adjust and no fix.
  - day < max_day → day + 1.
  - Otherwise day ← 1 and month + 1.
  - Month 12 rolls over → month ← 1 and year + 1.
  - Year YEAR_MAX rolls over → year ← 0 and year_wrap = 1 for that cycle.
  - tick_pending clears when the tick is applied.
- **Blocked tick:** a day_tick arriving in an adjust or fix cycle sets tick_pending (one deep).
  - A further day_tick while tick_pending = 1 and still blocked is dropped and sets tick_lost (held until rst).
  - A day_tick arriving in the same cycle a pending tick is applied is also dropped and sets tick_lost.
- **Latency:**
  - Outputs are registered; a tick or adjust is visible the cycle after its input pulse.
  - The clamp is visible 2 cycles after a month/year adjust.
- **Illegal day:** day is never 0 and never exceeds 31; an illegal combination (e.g. 31 Apr) may exist only during the single cycle before a fix.

Test Plan:
Bench instantiates the leap-year stage in the feedback loop.
1. rst for 2 cycles → day = 1, month = 1, year_bin = 2000, year_wrap = 0, tick_lost = 0; a day_tick in the same cycle as rst is ignored.
2. Preset 28 Feb 2000, 2 ticks → 29 Feb 2000, then 1 Mar 2000. Preset 28 Feb 1900, 1 tick → 1 Mar 1900. Preset 28 Feb 2024 → 29 Feb.
3. Preset 31 Dec 4095, 1 tick → 1 Jan 0, year_wrap high exactly 1 cycle. 31 Dec 1999 → 1 Jan 2000, no year_wrap.
4. 31 Mar 2001, adj_sel = 1 + adj_dec → 31 Feb next cycle, then 28 Feb the following cycle. 29 Feb 2000, adj_sel = 2 + adj_inc → 2001, then day = 28.
5. Adjust and day_tick in the same cycle on 10 Jan → adjust applied, tick deferred: day 11 (day adjust), day 12 one cycle later. Two ticks during consecutive adjust cycles → one applied, tick_lost = 1.
6. adj_inc and adj_dec together, or adj_sel = 3 → all outputs unchanged. Day dec on 1 Apr → 30 Apr; day inc on 30 Apr → 1 Apr.
